ldm_stm_sequencer: RTL

Multi-cycle sequencer for ARM block transfers (LDM/STM). It sits directly upstream of the 16x32 register file. It walks a 16-bit register list and drives register-file read/write addresses, RW and write data. It also runs the memory handshake and performs optional base-register writeback. The decode/control unit starts it; it holds busy until the transfer completes.

---
 rtl/ldm_stm_sequencer_pkg.sv | 23 ++
 rtl/ldm_stm_sequencer_priority_encoder.sv | 19 +
 rtl/ldm_stm_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
// Holds the FSM encoding, register-file RW levels and the list popcount helper.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } seqState_t;

  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;
  localparam int   WORD_BYTES = 4;

  function automatic logic [4:0] popCount16(input logic [15:0] bits);
    logic [4:0] count;
    count = '0;
    for (int i = 0; i < 16; i++) count = count + {4'd0, bits[i]};
    return count;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_priority_encoder.sv
// Lowest-set-bit encoder for a 16-bit register list.
// valid is low when no bit is set; index is then 0.
module priority_encoder_16 (
  input  logic [15:0] bits,
  output logic [3:0]  index,
  output logic        valid
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (bits[i]) index = 4'(i);
    end
  end

  assign valid = |bits;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM sequencer: walks the register list lowest-first, runs the memory
// handshake, drives the register-file ports and optionally writes back Rn.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic              load,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       reg_list,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        rf_read_address,
  output logic [3:0]        rf_write_address,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_rw,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] WordStep = ADDR_W'(WORD_BYTES);

  seqState_t         state;
  logic [15:0]       remaining;
  logic [15:0]       remainingRest;
  logic [ADDR_W-1:0] curAddr;
  logic [ADDR_W-1:0] wbValue;
  logic [ADDR_W-1:0] listBytes;
  logic [3:0]        baseRegQ;
  logic [3:0]        curIndex;
  logic              curValid;
  logic              loadQ;
  logic              doWb;
  logic              inXfer;
  logic              loadStrobe;

  priority_encoder_16 curEncoder (
    .bits  (remaining),
    .index (curIndex),
    .valid (curValid)
  );

  // Clearing the lowest bit leaves zero exactly when cur is the last register.
  assign remainingRest = remaining & (remaining - 16'd1);
  assign listBytes     = ADDR_W'(popCount16(reg_list)) * WordStep;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      remaining <= '0;
      curAddr   <= '0;
      wbValue   <= '0;
      baseRegQ  <= '0;
      loadQ     <= 1'b0;
      doWb      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            loadQ     <= load;
            baseRegQ  <= base_reg;
            remaining <= reg_list;
            // A loaded base register overrides the writeback value.
            doWb      <= writeback && !(load && reg_list[base_reg]);
            wbValue   <= up ? base_addr + listBytes : base_addr - listBytes;
            case ({pre, up})
              2'b01:   curAddr <= base_addr;
              2'b11:   curAddr <= base_addr + WordStep;
              2'b00:   curAddr <= base_addr - listBytes + WordStep;
              default: curAddr <= base_addr - listBytes;
            endcase
            state <= (reg_list == 16'd0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (mem_ready) begin
            remaining <= remainingRest;
            curAddr   <= curAddr + WordStep;
            if (remainingRest == 16'd0) state <= doWb ? WB : DONE;
          end
        end
        WB:      state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign inXfer     = (state == XFER) && curValid;
  assign loadStrobe = inXfer && loadQ && mem_ready;

  assign mem_req         = inXfer;
  assign mem_write       = inXfer && !loadQ;
  assign mem_addr        = inXfer ? {curAddr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata       = rf_rdata;
  assign rf_read_address = inXfer ? curIndex : 4'd0;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

  always_comb begin
    rf_rw            = RW_READ;
    rf_write_address = 4'd0;
    rf_wdata         = '0;
    if (inXfer) begin
      rf_write_address = curIndex;
      if (loadStrobe) begin
        rf_rw    = RW_WRITE;
        rf_wdata = mem_rdata;
      end
    end else if (state == WB) begin
      rf_rw            = RW_WRITE;
      rf_write_address = baseRegQ;
      rf_wdata         = wbValue;
    end
  end

endmodule
